// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter slice.
// Holds the default address/data widths, the upper requester limit, the
// register-file depth, and a small modular-increment helper for the
// round-robin search.
package regfile_wr_arbiter_pkg;

  localparam int unsigned RF_DEPTH    = 4;
  localparam int unsigned ADDR_W_DEF  = $clog2(RF_DEPTH);
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned NUM_REQ_MAX = 4;

  // Pointer/index width is sized for the largest supported requester count
  // so every instance shares one encoding.
  localparam int unsigned PTR_W = $clog2(NUM_REQ_MAX);

  // (base + step) mod n, used to walk the requesters starting after ptr.
  function automatic int unsigned rr_next(input int unsigned base,
                                          input int unsigned step,
                                          input int unsigned n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant logic.
//   valid : per-requester request vector
//   ptr   : index of the most recently granted requester
//   hold  : suppresses all grants while high
//   grant : one-hot grant (all zero when nothing valid or hold=1)
//   idx   : encoded index of the granted requester (0 when no grant)
// The search starts at ptr+1 and wraps, so the last winner has lowest priority.
module rr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx
);

  logic             found;
  logic [PTR_W-1:0] cidx;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cidx  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cidx = PTR_W'(rr_next(32'(ptr), k, NUM_REQ));
      if (!found && !hold && valid[cidx]) begin
        grant[cidx] = 1'b1;
        idx         = cidx;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the single write port of the register file
// among NUM_REQ valid/ready requesters using round-robin arbitration.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/addr/data   : packed per-requester write requests
//   req_ready             : one-hot grant, transfer when valid & ready
//   hold                  : freezes all grants while high
//   writeReg/Data/Enable  : registered write to the register file
//   readreg1/2            : register-file read addresses
//   fwd_hit1/2, fwd_data1/2 : bypass for a write still in flight
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  output logic [ADDR_W-1:0]         writeReg,
  output logic [DATA_W-1:0]         writeData,
  output logic                      writeEnable,
  input  logic [ADDR_W-1:0]         readreg1,
  input  logic [ADDR_W-1:0]         readreg2,
  output logic                      fwd_hit1,
  output logic                      fwd_hit2,
  output logic [DATA_W-1:0]         fwd_data1,
  output logic [DATA_W-1:0]         fwd_data2
);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   idx;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Reset is folded into hold so nothing is granted while reset is high and
  // a request pending across reset is re-arbitrated from the reset pointer.
  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .valid(req_valid),
    .ptr  (ptr),
    .hold (hold | reset),
    .grant(grant),
    .idx  (idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // One-hot operand mux driven by the grant vector.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= PTR_W'(NUM_REQ - 1);
      writeEnable <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
    end else if (accept) begin
      ptr         <= idx;
      writeEnable <= 1'b1;
      writeReg    <= sel_addr;
      writeData   <= sel_data;
    end else begin
      writeEnable <= 1'b0;
    end
  end

  // Bypass comparators work only from registered write state, so there is no
  // path from here back into the grant logic.
  assign fwd_hit1  = writeEnable & ~reset & (readreg1 == writeReg);
  assign fwd_hit2  = writeEnable & ~reset & (readreg2 == writeReg);
  assign fwd_data1 = fwd_hit1 ? writeData : '0;
  assign fwd_data2 = fwd_hit2 ? writeData : '0;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic. A predictor derives the expected grant from a priority
// list and queues each expected write; a monitor pops the queue against the
// registered write port and the bypass outputs.
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int AW = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   writeReg;
  logic [DW-1:0]   writeData;
  logic            writeEnable;
  logic [AW-1:0]   readreg1;
  logic [AW-1:0]   readreg2;
  logic            fwd_hit1;
  logic            fwd_hit2;
  logic [DW-1:0]   fwd_data1;
  logic [DW-1:0]   fwd_data2;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .NUM_REQ(N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .hold       (hold),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .writeEnable(writeEnable),
    .readreg1   (readreg1),
    .readreg2   (readreg2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int            checks = 0;
  int            fails  = 0;
  wr_t           expq[$];
  int            prio[$];          // requester ids, highest priority first
  logic [AW-1:0] last_reg  = '0;
  logic [DW-1:0] last_data = '0;
  logic [N-1:0]  xfer_mask = '0;

  logic          pend_v[N];
  logic [AW-1:0] pend_a[N];
  logic [DW-1:0] pend_d[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic reset_prio();
    prio.delete();
    for (int i = 0; i < N; i++) prio.push_back(i);
  endtask

  // Monitor: one expected write per cycle following an accept.
  initial begin : monitor
    wr_t           e;
    logic          exp_we;
    logic          h1, h2;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        last_reg  = e.a;
        last_data = e.d;
        exp_we    = 1'b1;
      end else begin
        exp_we = 1'b0;
      end
      chk("writeEnable", 64'(writeEnable), 64'(exp_we));
      chk("writeReg",    64'(writeReg),    64'(last_reg));
      chk("writeData",   64'(writeData),   64'(last_data));
      h1 = exp_we && !reset && (readreg1 == last_reg);
      h2 = exp_we && !reset && (readreg2 == last_reg);
      chk("fwd_hit1",  64'(fwd_hit1),  64'(h1));
      chk("fwd_hit2",  64'(fwd_hit2),  64'(h2));
      chk("fwd_data1", 64'(fwd_data1), h1 ? 64'(last_data) : 64'd0);
      chk("fwd_data2", 64'(fwd_data2), h2 ? 64'(last_data) : 64'd0);
      if (reset) begin
        last_reg  = '0;
        last_data = '0;
      end
    end
  end

  // Predictor: expected grant = first valid requester in the priority list;
  // the winner then moves to the back of the list.
  initial begin : predictor
    logic [N-1:0] exp_g;
    int           win;
    int           t;
    reset_prio();
    forever begin
      @(negedge clk);
      #1;
      exp_g = '0;
      win   = -1;
      if (!reset && !hold) begin
        foreach (prio[k]) begin
          if (win < 0 && req_valid[prio[k]]) win = prio[k];
        end
      end
      if (win >= 0) exp_g[win] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_g));
      xfer_mask = exp_g;
      if (reset) begin
        reset_prio();
      end else if (win >= 0) begin
        expq.push_back('{a: pend_a[win], d: pend_d[win]});
        while (prio[$] != win) begin
          t = prio.pop_front();
          prio.push_back(t);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (xfer_mask[i]) pend_v[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!pend_v[i]) begin
      pend_v[i] = 1'b1;
      pend_a[i] = a;
      pend_d[i] = d;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pend_v[i];
      req_addr[i*AW +: AW]    = pend_a[i];
      req_data[i*DW +: DW]    = pend_d[i];
    end
  endtask

  initial begin : driver
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_d[i] = '0;
    end
    reset    = 1'b1;
    hold     = 1'b0;
    readreg1 = '0;
    readreg2 = '0;
    apply();
    tick(); tick();
    reset = 1'b0;
    apply();

    // Single request after reset.
    readreg1 = 2'd2;
    set_req(0, 2'd2, 32'hDEADBEEF);
    apply();
    for (int c = 0; c < 3; c++) begin tick(); apply(); end

    // All requesters continuously valid.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) set_req(i, AW'(i), 32'h100 + 32'(c * N + i));
      apply();
      tick();
    end
    apply();
    tick(); apply();

    // Two requesters writing the same register.
    readreg1 = 2'd1;
    readreg2 = 2'd3;
    set_req(0, 2'd1, 32'h11);
    set_req(2, 2'd1, 32'h22);
    apply();
    for (int c = 0; c < 4; c++) begin tick(); apply(); end

    // Hold with all requesters valid, then release.
    hold = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, AW'(3 - i), 32'hA0 + 32'(i));
    apply();
    for (int c = 0; c < 3; c++) begin tick(); apply(); end
    hold = 1'b0;
    for (int c = 0; c < 5; c++) begin tick(); apply(); end

    // Reset while a write is in flight and requester 1 is pending.
    set_req(0, 2'd3, 32'h5555_0000);
    apply();
    tick();
    set_req(1, 2'd2, 32'h1234_5678);
    reset = 1'b1;
    apply();
    tick();
    reset = 1'b0;
    apply();
    for (int c = 0; c < 3; c++) begin tick(); apply(); end

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(1, 0) == 1) set_req(i, AW'($urandom), $urandom);
      hold     = ($urandom_range(9, 0) == 0);
      reset    = ($urandom_range(63, 0) == 0);
      readreg1 = AW'($urandom);
      readreg2 = AW'($urandom);
      apply();
      tick();
    end

    // Drain.
    hold  = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < N + 3; c++) begin apply(); tick(); end
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    apply();
    tick(); tick();
    chk("drain_pending", 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin arbiter sharing the single write port of the 4 x 32-bit register file among NUM_REQ requesters, e.g. ALU writeback, load unit and debug port. Each requester uses a valid/ready handshake. The winning write is registered and then driven onto the register file's writeReg/writeData/writeEnable inputs. The block also supplies bypass data for the two read ports while a write is in flight, so readers never see a stale value.

## Interface
- NUM_REQ, 3, number of requesters (2..4)
- ADDR_W, 2, register address width
- DATA_W, 32, register data width
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*ADDR_W  packed target register; requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed write data, same packing
- req_ready  output  NUM_REQ  one-hot grant; transfer when valid & ready
- hold  input  1  freeze: no grants while high
- writeReg  output  ADDR_W  to register file
- writeData  output  DATA_W  to register file
- writeEnable  output  1  to register file
- readreg1, readreg2  input  ADDR_W  read addresses, same as the register file's read ports
- fwd_hit1, fwd_hit2  output  1  in-flight write targets readregN
- fwd_data1, fwd_data2  output  DATA_W  bypass data (= writeData when hit, else 0)

## Operation
- Grant logic is combinational:
  - Search starts at ptr+1 (mod NUM_REQ) and wraps; the first requester with req_valid=1 wins.
  - req_ready is one-hot, or all zero if no valid request or hold=1.
- Requester rule: once req_valid is raised, req_valid, req_addr and req_data stay stable until req_ready=1.
- On an accepted transfer by requester i:
  - ptr <= i.
  - writeReg/writeData <= requester i's addr/data.
  - writeEnable <= 1.
- Cycle with no transfer (no valid, or hold=1): writeEnable <= 0; writeReg/writeData keep their last values; ptr unchanged.
- The register file commits at the rising edge that ends the cycle in which writeEnable=1. writeEnable is therefore a clean register output and never toggles mid-cycle.
- Forwarding: fwd_hitN = writeEnable & (readregN == writeReg). fwd_dataN = writeData when hit, else 0. This is purely combinational from registered state and the read address.
- Same address from two requesters in consecutive cycles: both writes proceed in grant order, and the later one wins in the register file.
- Reset:
  - writeEnable=0, writeReg=0, writeData=0.
  - ptr=NUM_REQ-1, so requester 0 has top priority first.
  - All fwd outputs 0 and req_ready=0 during reset.
  - A request pending when reset asserts is not accepted. If req_valid is still high after reset, it is re-arbitrated from the reset pointer.

## Timing
- Accept in cycle N -> writeEnable=1 in cycle N+1 -> value readable from the register file in cycle N+2. The fwd path covers cycle N+1.
- Throughput: one write per cycle, back-to-back, no bubbles.
- Requester fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- hold high in cycle N: no accept in N, writeEnable=0 in N+1. A write already registered in N still completes in N.
- No combinational path from writeEnable or the fwd outputs back to req_ready.

## Structure
- Shared include rf_defs.v holds:
  - ADDR_W/DATA_W defaults
  - NUM_REQ limit
  - RF_DEPTH=4
- Sub-module rr_arbiter (NUM_REQ): inputs valid vector, ptr and hold; outputs one-hot grant and encoded index. Purely combinational.
- regfile_wr_arbiter holds:
  - ptr register
  - output register stage
  - operand mux
  - two forwarding comparators
- Top-level pairing: regfile_wr_arbiter and the register file are instanced side by side.

## Test plan
- Reset then single request: req_valid=001, addr0=2, data0=0xDEADBEEF -> req_ready=001 the same cycle; next cycle writeEnable=1, writeReg=2; following cycle a read of reg 2 returns 0xDEADBEEF.
- All valid for 6 cycles -> grants 001,010,100,001,010,100; writeEnable stays 1 from cycle 2 to cycle 7.
- Requesters 0 and 2 both write reg 1 (0x11, then 0x22) -> grant order 0 then 2; reg 1 = 0x22 afterwards; fwd_hit1=1 with readreg1=1 in both write cycles, fwd_data1 = 0x11 then 0x22.
- hold=1 for 3 cycles with req_valid=111 -> req_ready=000 and writeEnable=0 in the next 3 cycles; ptr unchanged; after release the grant goes to the requester following the last granted one.
- reset asserted for 1 cycle while req_valid=010 is pending and writeEnable=1 -> next cycle writeEnable=0 and writeReg=0; after reset, requester 1 is granted and its write occurs exactly once.
